// File: rtl/pc_stack_unit.sv
// ============================================================================
// pc_stack_unit : program counter with a hardware return-address stack.
// Optional build macro PC_STACK_WRAP_EN makes a push into a full stack
// overwrite the oldest entry instead of being dropped with ovf set.
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_stack_unit #(
  parameter int AW = 16,
  parameter int DEPTH = 8,
  parameter logic [AW-1:0] VEC = {{(AW-1){1'b1}}, 1'b0}
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         ld,
  input  logic                         inc,
  input  logic                         rel,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         ld_reserved,
  input  logic                         err_clr,
  input  logic [AW-1:0]                data_in,
  input  logic [AW-1:0]                offset,
  output logic [AW-1:0]                data_out,
  output logic [AW-1:0]                top,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf,
  output logic                         udf
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH-1);
  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LVL_ONE = {{(LW-1){1'b0}}, 1'b1};

  logic [AW-1:0] pc;
  logic [LW-1:0] lvl;
  logic [PW-1:0] wp;          // next write slot; top lives at wp-1
  logic          ovf_q;
  logic          udf_q;
  logic [AW-1:0] mem [0:DEPTH-1];

  logic [PW-1:0] wp_inc;
  logic [PW-1:0] wp_dec;
  logic          full_w;
  logic          empty_w;
  logic [AW-1:0] top_val;

  logic [AW-1:0] pc_nxt;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_val;
  logic          push_en;
  logic          ovf_evt;
  logic          udf_evt;

  assign wp_inc  = (wp == PTR_MAX) ? '0 : wp + 1'b1;
  assign wp_dec  = (wp == '0) ? PTR_MAX : wp - 1'b1;
  assign full_w  = (lvl == LVL_MAX);
  assign empty_w = (lvl == '0);
  assign top_val = empty_w ? '0 : mem[wp_dec];

  // Strict priority: only the highest-priority request acts this cycle.
  always_comb begin
    pc_nxt   = pc;
    push     = 1'b0;
    pop      = 1'b0;
    push_val = pc;
    udf_evt  = 1'b0;
    if (ld) begin
      pc_nxt = data_in;
    end else if (call) begin
      push     = 1'b1;
      push_val = pc + PC_ONE;
      pc_nxt   = data_in;
    end else if (ret) begin
      if (!empty_w) begin
        pop    = 1'b1;
        pc_nxt = top_val;
      end else begin
        udf_evt = 1'b1;
      end
    end else if (ld_reserved) begin
      push     = 1'b1;
      push_val = pc;
      pc_nxt   = VEC;
    end else if (rel) begin
      pc_nxt = pc + offset;
    end else if (inc) begin
      pc_nxt = pc + PC_ONE;
    end
  end

`ifdef PC_STACK_WRAP_EN
  // When full, wp points at the oldest entry, so writing there recycles it.
  assign push_en = push;
  assign ovf_evt = 1'b0;
`else
  assign push_en = push && !full_w;
  assign ovf_evt = push && full_w;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      pc    <= '0;
      lvl   <= '0;
      wp    <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (push_en) begin
        wp <= wp_inc;
        if (!full_w) begin
          lvl <= lvl + LVL_ONE;
        end
      end else if (pop) begin
        wp  <= wp_dec;
        lvl <= lvl - LVL_ONE;
      end
      ovf_q <= ovf_evt | (ovf_q & ~err_clr);
      udf_q <= udf_evt | (udf_q & ~err_clr);
    end
  end

  // Storage is never reset; it is unobservable while the stack is empty.
  always_ff @(posedge clk) begin
    if (!clear && push_en) begin
      mem[wp] <= push_val;
    end
  end

  assign data_out = pc;
  assign top      = top_val;
  assign level    = lvl;
  assign full     = full_w;
  assign empty    = empty_w;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
// ============================================================================
// tb_pc_stack_unit : directed vector table, corner sequences and random
// stimulus against a queue-based reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_stack_unit;

  localparam int AW = 16;
  localparam int DEPTH = 4;
  localparam logic [15:0] VEC = 16'hFFFE;

  localparam logic [7:0] CLR  = 8'h80;
  localparam logic [7:0] LD   = 8'h40;
  localparam logic [7:0] CALL = 8'h20;
  localparam logic [7:0] RET  = 8'h10;
  localparam logic [7:0] LDR  = 8'h08;
  localparam logic [7:0] REL  = 8'h04;
  localparam logic [7:0] INC  = 8'h02;
  localparam logic [7:0] ECLR = 8'h01;

  logic clk = 1'b0;
  logic clear = 1'b0, ld = 1'b0, inc = 1'b0, rel = 1'b0, call = 1'b0;
  logic ret = 1'b0, ld_reserved = 1'b0, err_clr = 1'b0;
  logic [15:0] data_in = '0, offset = '0;
  logic [15:0] data_out, top;
  logic [2:0]  level;
  logic full, empty, ovf, udf;

  always #5 clk = ~clk;

  pc_stack_unit #(.AW(AW), .DEPTH(DEPTH), .VEC(VEC)) dut (
    .clk(clk), .clear(clear), .ld(ld), .inc(inc), .rel(rel), .call(call),
    .ret(ret), .ld_reserved(ld_reserved), .err_clr(err_clr),
    .data_in(data_in), .offset(offset), .data_out(data_out), .top(top),
    .level(level), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: PC plus a queue whose back is the top of stack.
  logic [15:0] m_pc = '0;
  logic [15:0] m_stk[$];
  logic m_ovf = 1'b0, m_udf = 1'b0;

  typedef struct {
    logic [7:0]  ops;
    logic [15:0] d;
    logic [15:0] o;
    logic [15:0] e_pc;
    logic [15:0] e_top;
    logic [2:0]  e_lvl;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
    logic        e_udf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [15:0] v, inout logic oe);
    if (m_stk.size() < DEPTH) begin
      m_stk.push_back(v);
    end else begin
`ifdef PC_STACK_WRAP_EN
      void'(m_stk.pop_front());
      m_stk.push_back(v);
`else
      oe = 1'b1;
`endif
    end
  endtask

  task automatic model_step(input logic [7:0] ops, input logic [15:0] d, input logic [15:0] o);
    logic oe, ue;
    oe = 1'b0;
    ue = 1'b0;
    if (ops & CLR) begin
      m_pc = 16'h0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (ops & LD) m_pc = d;
      else if (ops & CALL) begin
        model_push(m_pc + 16'd1, oe);
        m_pc = d;
      end else if (ops & RET) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else ue = 1'b1;
      end else if (ops & LDR) begin
        model_push(m_pc, oe);
        m_pc = VEC;
      end else if (ops & REL) m_pc = m_pc + o;
      else if (ops & INC) m_pc = m_pc + 16'd1;
      m_ovf = oe | (m_ovf & ((ops & ECLR) == 0));
      m_udf = ue | (m_udf & ((ops & ECLR) == 0));
    end
  endtask

  task automatic apply(input logic [7:0] ops, input logic [15:0] d, input logic [15:0] o);
    @(negedge clk);
    clear = ops[7]; ld = ops[6]; call = ops[5]; ret = ops[4];
    ld_reserved = ops[3]; rel = ops[2]; inc = ops[1]; err_clr = ops[0];
    data_in = d; offset = o;
    @(posedge clk);
    model_step(ops, d, o);
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic [15:0] et;
    int n;
    n  = m_stk.size();
    et = (n > 0) ? m_stk[n-1] : 16'h0;
    chk({tag, "_pc"},    data_out, m_pc);
    chk({tag, "_top"},   top, et);
    chk({tag, "_level"}, level, n);
    chk({tag, "_full"},  full, (n == DEPTH));
    chk({tag, "_empty"}, empty, (n == 0));
    chk({tag, "_ovf"},   ovf, m_ovf);
    chk({tag, "_udf"},   udf, m_udf);
  endtask

  initial begin
    // ops, data_in, offset, pc, top, level, full, empty, ovf, udf
    tbl.push_back('{CLR,       16'h0000, 16'h0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{LD,        16'h0100, 16'h0, 16'h0100, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{INC,       16'h0000, 16'h0, 16'h0101, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{INC,       16'h0000, 16'h0, 16'h0102, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{INC,       16'h0000, 16'h0, 16'h0103, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{LD,        16'h0010, 16'h0, 16'h0010, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{CALL,      16'h0200, 16'h0, 16'h0200, 16'h0011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{RET,       16'h0000, 16'h0, 16'h0011, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{LD,        16'h0050, 16'h0, 16'h0050, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{LDR,       16'h0000, 16'h0, 16'hFFFE, 16'h0050, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{INC,       16'h0000, 16'h0, 16'hFFFF, 16'h0050, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{INC,       16'h0000, 16'h0, 16'h0000, 16'h0050, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{RET,       16'h0000, 16'h0, 16'h0050, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{LD,        16'h0030, 16'h0, 16'h0030, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{RET,       16'h0000, 16'h0, 16'h0030, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{ECLR,      16'h0000, 16'h0, 16'h0030, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{REL,       16'h0000, 16'hFFF0, 16'h0020, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{CALL|RET,  16'h0300, 16'h0, 16'h0300, 16'h0021, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{RET,       16'h0000, 16'h0, 16'h0021, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{RET|ECLR,  16'h0000, 16'h0, 16'h0021, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{8'h00,     16'h0555, 16'h5, 16'h0021, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{REL|INC,   16'h0000, 16'h0005, 16'h0026, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{CLR|LD,    16'h1234, 16'h0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{REL,       16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{INC,       16'h0000, 16'h0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].ops, tbl[i].d, tbl[i].o);
      chk($sformatf("vec%0d_pc", i),    data_out, tbl[i].e_pc);
      chk($sformatf("vec%0d_top", i),   top,      tbl[i].e_top);
      chk($sformatf("vec%0d_level", i), level,    tbl[i].e_lvl);
      chk($sformatf("vec%0d_full", i),  full,     tbl[i].e_full);
      chk($sformatf("vec%0d_empty", i), empty,    tbl[i].e_empty);
      chk($sformatf("vec%0d_ovf", i),   ovf,      tbl[i].e_ovf);
      chk($sformatf("vec%0d_udf", i),   udf,      tbl[i].e_udf);
    end

    // Five calls from PC 0 into a four-deep stack.
    apply(CLR, 16'h0, 16'h0);
    for (int n = 1; n <= 5; n++) apply(CALL, 16'h1000 + n[15:0], 16'h0);
    chk("ovfl_pc", data_out, 16'h1005);
    chk("ovfl_level", level, 3'd4);
    chk("ovfl_full", full, 1'b1);
`ifdef PC_STACK_WRAP_EN
    chk("ovfl_ovf", ovf, 1'b0);
    chk("ovfl_top", top, 16'h1005);
    for (int n = 0; n < 4; n++) begin
      apply(RET, 16'h0, 16'h0);
      chk($sformatf("ovfl_ret%0d", n), data_out, 16'h1005 - n[15:0]);
    end
`else
    chk("ovfl_ovf", ovf, 1'b1);
    chk("ovfl_top", top, 16'h1004);
    for (int n = 0; n < 3; n++) begin
      apply(RET, 16'h0, 16'h0);
      chk($sformatf("ovfl_ret%0d", n), data_out, 16'h1004 - n[15:0]);
    end
    apply(RET, 16'h0, 16'h0);
    chk("ovfl_ret3", data_out, 16'h0001);
`endif
    chk("ovfl_empty", empty, 1'b1);
    apply(RET, 16'h0, 16'h0);
    chk_model("ovfl_under");

    // Clear wins over a simultaneous call with calls pending.
    for (int n = 0; n < 3; n++) apply(CALL, 16'h0400 + n[15:0], 16'h0);
    chk("pend_level", level, 3'd3);
    apply(CLR | CALL, 16'h0777, 16'h0);
    chk("clrcall_pc", data_out, 16'h0000);
    chk("clrcall_level", level, 3'd0);
    chk("clrcall_empty", empty, 1'b1);
    chk("clrcall_top", top, 16'h0000);
    chk("clrcall_ovf", ovf, 1'b0);
    chk("clrcall_udf", udf, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [7:0] ops;
      ops = 8'h00;
      if ($urandom_range(0, 59) == 0) ops |= CLR;
      if ($urandom_range(0, 7) == 0)  ops |= LD;
      if ($urandom_range(0, 3) == 0)  ops |= CALL;
      if ($urandom_range(0, 3) == 0)  ops |= RET;
      if ($urandom_range(0, 9) == 0)  ops |= LDR;
      if ($urandom_range(0, 3) == 0)  ops |= REL;
      if ($urandom_range(0, 1) == 0)  ops |= INC;
      if ($urandom_range(0, 7) == 0)  ops |= ECLR;
      apply(ops, 16'($urandom), 16'($urandom));
      chk_model($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
